fpu_wb_scheduler: RTL

- Shares the single FP register-file write port between two producers: the fixed-latency pipelined FPU (add/mul/cvt), which cannot be stalled, and the iterative fdiv/fsqrt unit, which can wait.
- Tracks the destination register of the one in-flight iterative op and stalls dependent instructions at issue.
- Buffers an iterative result in a one-entry hold register when it loses arbitration.
- Sits between the FPU execute units and the FP register file write port; supports cancellation on interrupt/flush.

---
 rtl/fpu_wb_scheduler_if.sv | 38 +++
 rtl/fpu_wb_scheduler.sv | 85 ++++++++
 2 files changed

// File: rtl/fpu_wb_scheduler_if.sv
// Bundle between the FP execute units / issue stage and the regfile write-port scheduler.
interface fpu_wb_scheduler_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          p_valid;
  logic [AW-1:0] p_rd;
  logic [DW-1:0] p_data;
  logic          d_issue;
  logic [AW-1:0] d_issue_rd;
  logic          d_busy;
  logic          d_valid;
  logic [DW-1:0] d_data;
  logic          d_ready;
  logic          cancel;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rs3;
  logic [AW-1:0] rd_chk;
  logic          stall;
  logic          wb_we;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  // Scheduler side
  modport slave (
    input  p_valid, p_rd, p_data, d_issue, d_issue_rd, d_valid, d_data, cancel,
           rs1, rs2, rs3, rd_chk,
    output d_busy, d_ready, stall, wb_we, wb_rd, wb_data
  );

  // Producer / issue-stage side
  modport master (
    output p_valid, p_rd, p_data, d_issue, d_issue_rd, d_valid, d_data, cancel,
           rs1, rs2, rs3, rd_chk,
    input  d_busy, d_ready, stall, wb_we, wb_rd, wb_data
  );
endinterface

// File: rtl/fpu_wb_scheduler.sv
// Arbitrates the single FP regfile write port between the unstallable pipelined FPU
// and the iterative fdiv/fsqrt unit, tracking the iterative destination for hazards.
module fpu_wb_scheduler #(
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                  clk,
  input  logic                  clrn,
  fpu_wb_scheduler_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] pend_rd;
  logic [DW-1:0] hold_data;
  logic [NREG-1:0] pend_hot;

  // One-hot view of the pending destination for the source/dest hazard lookup
  assign pend_hot = NREG'(1) << pend_rd;

  // Status and hazard outputs; stall clears the same edge the pending write lands
  assign bus.d_busy  = (state != IDLE);
  assign bus.d_ready = (state == PEND) && !bus.cancel;
  assign bus.stall   = (state != IDLE) &&
                       (pend_hot[bus.rs1] || pend_hot[bus.rs2] ||
                        pend_hot[bus.rs3] || pend_hot[bus.rd_chk]);

  // FSM and registered write port; the pipelined FPU always wins the port
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      pend_rd     <= '0;
      hold_data   <= '0;
      bus.wb_we   <= 1'b0;
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
    end else begin
      bus.wb_we <= 1'b0;
      if (bus.p_valid) begin
        bus.wb_we   <= 1'b1;
        bus.wb_rd   <= bus.p_rd;
        bus.wb_data <= bus.p_data;
      end
      case (state)
        IDLE: begin
          if (bus.d_issue && !bus.cancel) begin
            pend_rd <= bus.d_issue_rd;
            state   <= PEND;
          end
        end
        PEND: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else if (bus.d_valid) begin
            if (bus.p_valid) begin
              hold_data <= bus.d_data;
              state     <= HOLD;
            end else begin
              bus.wb_we   <= 1'b1;
              bus.wb_rd   <= pend_rd;
              bus.wb_data <= bus.d_data;
              state       <= IDLE;
            end
          end
        end
        HOLD: begin
          if (!bus.p_valid) begin
            bus.wb_we   <= 1'b1;
            bus.wb_rd   <= pend_rd;
            bus.wb_data <= hold_data;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
